tx_frame_controller: RTL and testbench
======================================

Name: tx_frame_controller

Overview:
Frame sequencer placed in front of the QPSK modulator byte input, driving the packer's byte handshake. On a start command it emits a preamble and a 2-byte length header, then passes a counted payload from the upstream source. It finishes with zero-byte flush beats that drain the spreader, FIFO and FIR, followed by an inter-frame gap. It turns a free-running byte stream into bounded, self-delimiting bursts and supports abort.

Parameters:
SIZE_INPUT_BIT, 8, byte width on both sides; header fields are this wide.
PREAMBLE_LEN, 4, number of preamble beats (>=1).
PREAMBLE_BYTE, 8'h55, value of each preamble beat.
FLUSH_LEN, 16, number of 8'h00 flush beats after payload (>=1).
GAP_CYCLES, 8, idle clocks after flush before return to idle (0 allowed).
LEN_WIDTH, 16, payload length counter width; header is 2 beats, fixed for LEN_WIDTH=16.

Ports:
i_clk  in  1  system clock, all logic rising-edge.
i_reset  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert assumed upstream.
i_start  in  1  start request, sampled only in IDLE.
i_abort  in  1  abort request, sampled in any non-IDLE state.
i_length  in  LEN_WIDTH  payload byte count, captured on accepted i_start.
i_data  in  SIZE_INPUT_BIT  upstream payload byte.
i_valid_input  in  1  upstream byte valid.
o_ready  out  1  upstream ready, active only in PAYLOAD.
o_data  out  SIZE_INPUT_BIT  byte to packer.
o_valid  out  1  byte valid to packer.
i_ready_output  in  1  packer ready.
o_busy  out  1  high in any state other than IDLE.
o_done  out  1  one-cycle pulse on final cycle of a frame.
o_aborted  out  1  one-cycle pulse coincident with o_done when the frame was aborted.
o_state  out  3  current state encoding, debug.

Behaviour:
- Reset (i_reset=0, async): state IDLE; o_valid=0, o_ready=0, o_busy=0, o_done=0, o_aborted=0, o_data=0, o_state=IDLE; counters and abort-pending flag cleared. Reset mid-frame discards the frame; no done pulse.
- Beat = cycle with o_valid && i_ready_output. Once o_valid=1 in a generated state (PREAMBLE/HEADER/FLUSH), o_valid and o_data hold until the beat completes.
- IDLE: o_valid=0, o_ready=0. i_start=1 at cycle N captures i_length; the state is PREAMBLE at N+1 with o_valid=1 and o_data=PREAMBLE_BYTE. i_abort is ignored in IDLE. i_start in other states is ignored.
- PREAMBLE: PREAMBLE_LEN beats of PREAMBLE_BYTE, then HEADER.
- HEADER: beat 0 = length[15:8], beat 1 = length[7:0], then PAYLOAD. If length=0, go to FLUSH instead.
- PAYLOAD: combinational passthrough, zero latency. o_data=i_data, o_valid=i_valid_input, o_ready=i_ready_output. Each beat decrements the remaining count; the beat that makes it 0 moves the state to FLUSH. Upstream stalls just wait; there is no timeout.
- FLUSH: FLUSH_LEN beats of 8'h00, then GAP. If GAP_CYCLES=0, the last flush beat is the final cycle.
- GAP: o_valid=0 for GAP_CYCLES cycles; the last gap cycle is the final cycle; next cycle is IDLE.
- o_done pulses on the final cycle; o_busy deasserts the following cycle. Back-to-back: i_start on the first IDLE cycle is accepted.
- Abort: i_abort=1 in PREAMBLE/HEADER/PAYLOAD sets abort-pending. Transition to FLUSH occurs on the first cycle where o_valid=0 or a beat completes, so no offered byte is ever withdrawn. The full flush and gap still run. Abort in FLUSH/GAP sets o_aborted on the final cycle but changes nothing else.
- o_ready=0 outside PAYLOAD, including the cycle after the final payload beat.

Decomposition:
- tx_frame_pkg: state enum (IDLE, PREAMBLE, HEADER, PAYLOAD, FLUSH, GAP; 3-bit encoding exported for o_state), FLUSH_BYTE=8'h00, HEADER_BEATS=2.
- Single module; one shared beat/gap down-counter reloaded on each state entry. No sub-module.

Test Plan:
- Length 3, payload D0 D1 D2, i_ready_output=1, i_valid_input=1, i_start at N -> beats N+1..N+25 carry 55 55 55 55 00 03 D0 D1 D2 then 16x00; o_valid=0 N+26..N+33; o_done at N+33; o_busy=0 at N+34.
- Length 0 -> 55x4, 00 00, 16x00; o_ready never asserted; o_done after 8 gap cycles.
- Length 2, i_ready_output low for 3 cycles during header beat 0 -> o_data holds 8'h00 with o_valid=1 throughout the stall; sequence is unchanged, done 3 cycles later.
- Length 100, i_abort pulsed after 10 payload beats while i_valid_input=1 and i_ready_output=0 -> byte held until accepted; then 16x00 flush; o_done and o_aborted pulse together.
- i_start while busy, and i_start+i_abort in IDLE -> first ignored, second starts a normal frame with o_aborted=0.
- i_reset=0 asynchronously mid-PAYLOAD -> o_valid, o_ready, o_busy go 0 immediately with no done pulse; a new frame after reset runs correctly.

Source files
------------

// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the transmit frame sequencer.
package tx_frame_pkg;

  // Frame sequencer states; the 3-bit encoding is exported on o_state.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_GAP      = 3'd5
  } state_e;

  // Byte value sent on every flush beat.
  localparam logic [7:0] FLUSH_BYTE = 8'h00;

  // Length header is always two beats, MSB first.
  localparam int HEADER_BEATS = 2;

endpackage

// File: rtl/tx_frame_controller.sv
// Frame sequencer in front of the modulator byte input: preamble, 2-byte
// length header, counted payload passthrough, zero flush and idle gap.
module tx_frame_controller
  import tx_frame_pkg::*;
#(
  parameter int          SIZE_INPUT_BIT = 8,
  parameter int          PREAMBLE_LEN   = 4,
  parameter logic [7:0]  PREAMBLE_BYTE  = 8'h55,
  parameter int          FLUSH_LEN      = 16,
  parameter int          GAP_CYCLES     = 8,
  parameter int          LEN_WIDTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [LEN_WIDTH-1:0]      i_length,
  input  logic [SIZE_INPUT_BIT-1:0] i_data,
  input  logic                      i_valid_input,
  output logic                      o_ready,
  output logic [SIZE_INPUT_BIT-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready_output,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_aborted,
  output logic [2:0]                o_state
);

  localparam logic [LEN_WIDTH-1:0] CNT_ONE      = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] CNT_PREAMBLE = LEN_WIDTH'(PREAMBLE_LEN - 1);
  localparam logic [LEN_WIDTH-1:0] CNT_HEADER   = LEN_WIDTH'(HEADER_BEATS - 1);
  localparam logic [LEN_WIDTH-1:0] CNT_FLUSH    = LEN_WIDTH'(FLUSH_LEN - 1);
  localparam logic [LEN_WIDTH-1:0] CNT_GAP      = LEN_WIDTH'(GAP_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;     // shared beat/gap/payload down-counter
  logic [LEN_WIDTH-1:0]   len_q, len_d;     // captured payload length for the header
  logic                   abort_q, abort_d; // abort requested during this frame

  logic                      valid_s;
  logic                      ready_s;
  logic [SIZE_INPUT_BIT-1:0] data_s;
  logic                      beat_s;
  logic                      abort_pend_s;
  logic                      done_s;

  // Output byte/valid selection; generated bytes come only from registered state so they hold under stall.
  always_comb begin
    valid_s = 1'b0;
    ready_s = 1'b0;
    data_s  = '0;
    case (state_q)
      ST_PREAMBLE: begin
        valid_s = 1'b1;
        data_s  = SIZE_INPUT_BIT'(PREAMBLE_BYTE);
      end
      ST_HEADER: begin
        valid_s = 1'b1;
        if (cnt_q != '0) begin
          data_s = len_q[2*SIZE_INPUT_BIT-1 -: SIZE_INPUT_BIT];
        end else begin
          data_s = len_q[SIZE_INPUT_BIT-1:0];
        end
      end
      ST_PAYLOAD: begin
        valid_s = i_valid_input;
        ready_s = i_ready_output;
        data_s  = i_data;
      end
      ST_FLUSH: begin
        valid_s = 1'b1;
        data_s  = SIZE_INPUT_BIT'(FLUSH_BYTE);
      end
      default: begin
        valid_s = 1'b0;
      end
    endcase
  end

  assign beat_s       = valid_s && i_ready_output;
  assign abort_pend_s = abort_q || i_abort;

  // Final-cycle detection: last gap cycle, or the last flush beat when there is no gap.
  always_comb begin
    if (state_q == ST_GAP && cnt_q == '0) begin
      done_s = 1'b1;
    end else if (GAP_CYCLES == 0 && state_q == ST_FLUSH && cnt_q == '0 && beat_s) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Next-state logic; a pending abort leaves for FLUSH only once no byte is being offered unaccepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (i_start) begin
          state_d = ST_PREAMBLE;
          cnt_d   = CNT_PREAMBLE;
          len_d   = i_length;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE, ST_HEADER, ST_PAYLOAD: begin
        abort_d = abort_pend_s;
        if (abort_pend_s && (!valid_s || beat_s)) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_FLUSH;
        end else if (!beat_s) begin
          state_d = state_q;
        end else if (state_q == ST_PAYLOAD) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_FLUSH;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (state_q == ST_PREAMBLE) begin
          state_d = ST_HEADER;
          cnt_d   = CNT_HEADER;
        end else if (len_q == '0) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_FLUSH;
        end else begin
          state_d = ST_PAYLOAD;
          cnt_d   = len_q;
        end
      end
      ST_FLUSH: begin
        abort_d = abort_pend_s;
        if (!beat_s) begin
          state_d = ST_FLUSH;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
        end else begin
          state_d = ST_GAP;
          cnt_d   = CNT_GAP;
        end
      end
      ST_GAP: begin
        abort_d = abort_pend_s;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          abort_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset discarding any frame in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      abort_q <= abort_d;
    end
  end

  assign o_valid   = valid_s;
  assign o_ready   = ready_s;
  assign o_data    = data_s;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_s;
  assign o_aborted = done_s && abort_pend_s;
  assign o_state   = state_q;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed bench for tx_frame_controller with hand-computed expectations.
module tb_tx_frame_controller;
  import tx_frame_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] length;
  logic [7:0]  din;
  logic        vin;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        rdy_out;
  logic        o_busy;
  logic        o_done;
  logic        o_aborted;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  // frame run configuration and results
  int         cfg_len, cfg_stall_from, cfg_stall_len, cfg_abort_after, cfg_start_pulse;
  logic       cfg_abort_with_start;
  logic [7:0] beats[$];
  logic [8:0] stall_data[$];
  logic [7:0] exp_q[$];
  int         done_cyc;
  logic       abrt_seen, ready_seen, busy_after;

  tx_frame_controller dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_length(length), .i_data(din), .i_valid_input(vin), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready_output(rdy_out),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // expected beat list: 4x55, length MSB/LSB, payload D0.., 16x00
  task automatic build_exp(input int len, input int npay);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'(len >> 8));
    exp_q.push_back(8'(len & 255));
    for (int i = 0; i < npay; i++) exp_q.push_back(8'(8'hD0 + i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
  endtask

  task automatic cmp_beats(input string tag);
    int n;
    chk({tag, "_nbeats"}, beats.size(), exp_q.size());
    n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), int'(beats[i]), int'(exp_q[i]));
  endtask

  // Runs one frame starting at the current negedge (cycle 0 = start sampled).
  task automatic run_frame();
    int cyc;
    int pidx;
    int abort_cyc;
    beats.delete();
    stall_data.delete();
    done_cyc = -1; abrt_seen = 1'b0; ready_seen = 1'b0; busy_after = 1'b1;
    pidx = 0; abort_cyc = -1;
    start = 1'b1; abort = cfg_abort_with_start; length = 16'(cfg_len);
    vin = 1'b1; rdy_out = 1'b1; din = 8'hD0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; cyc = 1;
    for (int k = 0; k < 300; k++) begin
      if (cfg_abort_after >= 0 && abort_cyc < 0 && pidx == cfg_abort_after && o_state == ST_PAYLOAD)
        abort_cyc = cyc;
      start = (cyc == cfg_start_pulse);
      abort = (cyc == abort_cyc);
      rdy_out = !((cyc >= cfg_stall_from && cyc < cfg_stall_from + cfg_stall_len) ||
                  (abort_cyc >= 0 && cyc >= abort_cyc && cyc < abort_cyc + 3));
      din = 8'(8'hD0 + pidx);
      #1;
      if (!rdy_out) stall_data.push_back({o_valid, o_data});
      if (o_ready) ready_seen = 1'b1;
      if (o_valid && rdy_out) begin
        beats.push_back(o_data);
        if (o_state == ST_PAYLOAD) pidx++;
      end
      if (o_done) begin
        done_cyc = cyc;
        abrt_seen = o_aborted;
      end
      @(negedge clk);
      cyc++;
      if (done_cyc >= 0) begin
        busy_after = o_busy;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic cfg_default(input int len);
    cfg_len = len; cfg_stall_from = -1; cfg_stall_len = 0; cfg_abort_after = -1;
    cfg_start_pulse = -1; cfg_abort_with_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; length = 16'h0000;
    din = 8'h00; vin = 1'b0; rdy_out = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_data", o_data, 0);
    chk("rst_state", o_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // length 3, continuous flow
    cfg_default(3);
    run_frame();
    build_exp(3, 3);
    cmp_beats("len3");
    chk("len3_done_cyc", done_cyc, 33);
    chk("len3_busy_after", busy_after, 0);
    chk("len3_aborted", abrt_seen, 0);

    // length 0: header then straight to flush, back-to-back start
    cfg_default(0);
    run_frame();
    build_exp(0, 0);
    cmp_beats("len0");
    chk("len0_done_cyc", done_cyc, 30);
    chk("len0_ready_seen", ready_seen, 0);
    chk("len0_busy_after", busy_after, 0);

    // length 2, packer stalls 3 cycles on header beat 0
    cfg_default(2);
    cfg_stall_from = 5; cfg_stall_len = 3;
    run_frame();
    build_exp(2, 2);
    cmp_beats("stall");
    chk("stall_done_cyc", done_cyc, 35);
    chk("stall_nheld", stall_data.size(), 3);
    foreach (stall_data[i]) chk($sformatf("stall_held%0d", i), int'(stall_data[i]), int'({1'b1, 8'h00}));

    // length 100, abort after 10 payload beats while packer is stalled
    cfg_default(100);
    cfg_abort_after = 10;
    run_frame();
    build_exp(100, 11);
    cmp_beats("abort");
    chk("abort_done_cyc", done_cyc, 44);
    chk("abort_aborted", abrt_seen, 1);
    chk("abort_nheld", stall_data.size(), 3);
    foreach (stall_data[i]) chk($sformatf("abort_held%0d", i), int'(stall_data[i]), int'({1'b1, 8'hDA}));

    // start while busy ignored; start with abort in IDLE is a normal frame
    cfg_default(3);
    cfg_start_pulse = 10; cfg_abort_with_start = 1'b1;
    run_frame();
    build_exp(3, 3);
    cmp_beats("ign");
    chk("ign_done_cyc", done_cyc, 33);
    chk("ign_aborted", abrt_seen, 0);
    chk("ign_busy_after", busy_after, 0);

    // asynchronous reset mid-payload
    start = 1'b1; length = 16'd100; vin = 1'b1; rdy_out = 1'b1; din = 8'hD0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("mid_state_payload", o_state, int'(ST_PAYLOAD));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    chk("arst_state", o_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", o_busy, 0);
    @(negedge clk);

    cfg_default(1);
    run_frame();
    build_exp(1, 1);
    cmp_beats("after_rst");
    chk("after_rst_done_cyc", done_cyc, 31);
    chk("after_rst_aborted", abrt_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
